// File: rtl/scratch_pkg.sv
// Shared types and constants for the Wishbone block mover.
// Contents:
//   mover_state_t  - FSM state encoding for wb_block_mover
//   MODE_FILL/COPY - values of mode_i, latched at start
//   SEL_WORD       - byte-select pattern for a full 32-bit word cycle
package scratch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RGAP = 3'd2,
    WR   = 3'd3,
    WGAP = 3'd4,
    FIN  = 3'd5
  } mover_state_t;

  localparam logic       MODE_FILL = 1'b0;
  localparam logic       MODE_COPY = 1'b1;
  localparam logic [3:0] SEL_WORD  = 4'hF;

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog for the block mover.
// Ports:
//   clk_i   in  clock, rising edge
//   rst_i   in  synchronous active-high reset
//   clr     in  restart the count (a new bus cycle is about to begin)
//   run     in  strobe is out and no acknowledge has arrived this cycle
//   expired out high in the cycle whose edge would make the count reach TIMEOUT
module bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // clr only happens while the bus is idle, so it never competes with run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

  // Flag one cycle early so the abort lands on the edge where the count hits TIMEOUT,
  // giving exactly TIMEOUT cycles of strobe without an acknowledge.
  assign expired = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_block_mover.sv
// Wishbone-classic initiator that fills or copies a block of 32-bit words, one
// single-word cycle at a time, with a bus timeout.
// Ports:
//   clk_i, rst_i           clock and synchronous active-high reset
//   start_i, mode_i        start pulse (IDLE only) and 0=fill / 1=copy
//   src_i, dst_i, cnt_i    source/destination byte addresses and word count
//   pat_i                  fill pattern
//   busy_o, done_o, err_o  status: in progress, completion pulse, sticky timeout
//   cyc_o, stb_o, we_o, sel_o, adr_o, dat_o   registered Wishbone master outputs
//   dat_i, ack_i           Wishbone responder read data and acknowledge
import scratch_pkg::*;

module wb_block_mover #(
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [31:0]     src_i,
  input  logic [31:0]     dst_i,
  input  logic [CNTW-1:0] cnt_i,
  input  logic [31:0]     pat_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            cyc_o,
  output logic            stb_o,
  output logic            we_o,
  output logic [3:0]      sel_o,
  output logic [31:0]     adr_o,
  output logic [31:0]     dat_o,
  input  logic [31:0]     dat_i,
  input  logic            ack_i
);

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  mover_state_t    state_q, state_d;
  logic            mode_q;
  logic [31:0]     src_q, dst_q, pat_q, data_q;
  logic [CNTW-1:0] cnt_q;

  logic            ack_ok;
  logic            start_ok;
  logic            bus_state;
  logic            wd_clr, wd_run, wd_expired;
  logic            cyc_d, we_d, busy_d;
  logic [31:0]     adr_d, dat_d;

  // An acknowledge only counts while our own cycle is actually on the bus.
  assign ack_ok    = cyc_o & ack_i;
  assign start_ok  = (state_q == IDLE) & start_i;
  assign bus_state = (state_q == RD) || (state_q == WR);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (wd_clr),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cnt_i == '0)              state_d = FIN;
          else if (mode_i == MODE_COPY) state_d = RD;
          else                          state_d = WR;
        end
      end
      RD: begin
        if (ack_ok)          state_d = RGAP;
        else if (wd_expired) state_d = FIN;
      end
      RGAP: state_d = WR;
      WR: begin
        if (ack_ok)          state_d = WGAP;
        else if (wd_expired) state_d = FIN;
      end
      WGAP: begin
        if (cnt_q == '0)              state_d = FIN;
        else if (mode_q == MODE_COPY) state_d = RD;
        else                          state_d = WR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered bus outputs: the strobe is requested in RD/WR and
  // withdrawn on the same edge that samples the acknowledge or the timeout.
  always_comb begin
    cyc_d  = bus_state && !ack_ok && !wd_expired;
    we_d   = cyc_d && (state_q == WR);
    adr_d  = '0;
    dat_d  = '0;
    if (cyc_d) begin
      adr_d = ((state_q == WR) ? dst_q : src_q) & ADDR_MASK;
    end
    if (we_d) begin
      dat_d = (mode_q == MODE_COPY) ? data_q : pat_q;
    end
    busy_d = (state_d != IDLE);
    wd_clr = ((state_d == RD) || (state_d == WR)) && (state_d != state_q);
    wd_run = cyc_o && !ack_i;
  end

  // Registered outputs and the transfer datapath. Addresses are kept at full width so
  // they wrap naturally modulo 2**32; the low two bits are masked on the way out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_o  <= 1'b0;
      we_o   <= 1'b0;
      adr_o  <= '0;
      dat_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      mode_q <= MODE_FILL;
      src_q  <= '0;
      dst_q  <= '0;
      pat_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      cyc_o  <= cyc_d;
      we_o   <= we_d;
      adr_o  <= adr_d;
      dat_o  <= dat_d;
      busy_o <= busy_d;
      done_o <= (state_q == FIN);
      if (start_ok) begin
        mode_q <= mode_i;
        src_q  <= src_i;
        dst_q  <= dst_i;
        cnt_q  <= cnt_i;
        pat_q  <= pat_i;
        err_o  <= 1'b0;
      end
      if ((state_q == RD) && ack_ok) begin
        data_q <= dat_i;
        src_q  <= src_q + 32'd4;
      end
      if ((state_q == WR) && ack_ok) begin
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - CNTW'(1);
      end
      if (bus_state && !ack_ok && wd_expired) begin
        err_o <= 1'b1;
      end
    end
  end

  assign stb_o = cyc_o;
  assign sel_o = cyc_o ? SEL_WORD : 4'h0;

endmodule

// File: tb/tb_wb_block_mover.sv
// Testbench for wb_block_mover: drives a scratch-memory responder and compares
// memory contents against a word-level reference model of fill/copy.
module tb_wb_block_mover;
  import scratch_pkg::*;

  localparam int TIMEOUT = 64;
  localparam int CNTW    = 16;
  localparam int MEMW    = 256;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            mode_i;
  logic [31:0]     src_i, dst_i, pat_i;
  logic [CNTW-1:0] cnt_i;
  logic            busy_o, done_o, err_o;
  logic            cyc_o, stb_o, we_o;
  logic [3:0]      sel_o;
  logic [31:0]     adr_o, dat_o, dat_i;
  logic            ack_i;

  always #5 clk_i = ~clk_i;

  wb_block_mover #(.TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .src_i   (src_i),
    .dst_i   (dst_i),
    .cnt_i   (cnt_i),
    .pat_i   (pat_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .cyc_o   (cyc_o),
    .stb_o   (stb_o),
    .we_o    (we_o),
    .sel_o   (sel_o),
    .adr_o   (adr_o),
    .dat_o   (dat_o),
    .dat_i   (dat_i),
    .ack_i   (ack_i)
  );

  // Scratch-memory responder: registered read data, ack after 0..2 wait cycles,
  // ack only visible while the cycle is still held.
  logic [31:0] mem [MEMW];
  logic [31:0] model [MEMW];
  logic        ack_q, resp_en;
  logic [1:0]  wait_cnt;
  logic [31:0] rdata_q;
  logic [7:0]  idx;

  assign idx   = adr_o[9:2];
  assign ack_i = ack_q & cyc_o;
  assign dat_i = rdata_q;

  always @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      wait_cnt <= 2'd0;
      rdata_q  <= '0;
      for (int i = 0; i < MEMW; i++) mem[i] <= '0;
    end else if (cyc_o && stb_o && !ack_q && resp_en) begin
      if (wait_cnt == 2'd0) begin
        ack_q    <= 1'b1;
        wait_cnt <= 2'($urandom_range(0, 2));
        if (we_o) mem[idx] <= dat_o;
        else      rdata_q  <= mem[idx];
      end else begin
        wait_cnt <= wait_cnt - 2'd1;
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  int   total = 0;
  int   bad   = 0;
  int   wr_acks, rd_acks, done_cnt, cyc_rises, max_run, run_len;
  logic gap_ok, prev_cyc;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle bus monitor: format of every cycle, idle gap between acks, activity counts.
  always @(negedge clk_i) begin
    if (rst_i) begin
      gap_ok   = 1'b1;
      prev_cyc = 1'b0;
      run_len  = 0;
    end else begin
      checkOutput("bus_fmt", {adr_o[31:10], adr_o[1:0], stb_o, sel_o},
                  {22'd0, 2'b00, cyc_o, (cyc_o ? 4'hF : 4'h0)});
      if (!cyc_o) begin
        gap_ok  = 1'b1;
        run_len = 0;
      end else begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (!prev_cyc) cyc_rises++;
      end
      if (ack_i) begin
        checkOutput("ack_gap", gap_ok, 1'b1);
        gap_ok = 1'b0;
        if (we_o) wr_acks++;
        else      rd_acks++;
      end
      if (done_o) done_cnt++;
      prev_cyc = cyc_o;
    end
  end

  task automatic applyStimulus(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                               input logic [CNTW-1:0] cnt, input logic [31:0] pat);
    @(negedge clk_i);
    wr_acks = 0; rd_acks = 0; done_cnt = 0; cyc_rises = 0; max_run = 0;
    start_i = 1'b1; mode_i = mode; src_i = src; dst_i = dst; cnt_i = cnt; pat_i = pat;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (!done_o) checkOutput("done_timeout", done_o, 1'b1);
  endtask

  // Reference behaviour: word n of the block is handled in order, so a copy reads the
  // current contents of src+n just before writing dst+n.
  task automatic modelOp(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                         input int cnt, input logic [31:0] pat);
    for (int n = 0; n < cnt; n++) begin
      if (mode == MODE_COPY) model[8'(dst / 4 + n)] = model[8'(src / 4 + n)];
      else                   model[8'(dst / 4 + n)] = pat;
    end
  endtask

  task automatic finishOp(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                          input int cnt, input logic [31:0] pat);
    int diffs = 0;
    waitDone(cnt * 40 + 100);
    @(negedge clk_i);
    checkOutput("done_width", done_o, 1'b0);
    checkOutput("busy_after", busy_o, 1'b0);
    checkOutput("done_count", done_cnt, 1);
    checkOutput("err_clean", err_o, 1'b0);
    checkOutput("wr_acks", wr_acks, cnt);
    checkOutput("rd_acks", rd_acks, (mode == MODE_COPY) ? cnt : 0);
    modelOp(mode, src, dst, cnt, pat);
    for (int n = 0; n < cnt; n++)
      checkOutput("mem_word", mem[8'(dst / 4 + n)], model[8'(dst / 4 + n)]);
    for (int i = 0; i < MEMW; i++) if (mem[i] !== model[i]) diffs++;
    checkOutput("mem_all", diffs, 0);
  endtask

  task automatic runOp(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                       input int cnt, input logic [31:0] pat);
    applyStimulus(mode, src, dst, CNTW'(cnt), pat);
    finishOp(mode, src, dst, cnt, pat);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int          waited;
    logic [31:0] p;
    rst_i = 1'b1; start_i = 1'b0; mode_i = MODE_FILL; resp_en = 1'b1;
    src_i = '0; dst_i = '0; cnt_i = '0; pat_i = '0;
    wr_acks = 0; rd_acks = 0; done_cnt = 0; cyc_rises = 0; max_run = 0;
    for (int i = 0; i < MEMW; i++) model[i] = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("reset_outputs",
                {busy_o, done_o, err_o, cyc_o, stb_o, we_o, sel_o, adr_o[15:0], dat_o[15:0]}, '0);
    rst_i = 1'b0;

    $display("[TB] fill block");
    runOp(MODE_FILL, 32'h0, 32'h100, 4, 32'hDEADBEEF);
    checkOutput("fill_word3", mem[67], 32'hDEADBEEF);

    $display("[TB] copy block");
    runOp(MODE_FILL, 32'h0, 32'h0, 1, 32'd1);
    runOp(MODE_FILL, 32'h0, 32'h4, 1, 32'd2);
    runOp(MODE_FILL, 32'h0, 32'h8, 1, 32'd3);
    runOp(MODE_COPY, 32'h0, 32'h200, 3, 32'h0);
    checkOutput("copy_words", {mem[128], mem[129], mem[130]}, {32'd1, 32'd2, 32'd3});

    $display("[TB] zero count");
    applyStimulus(MODE_FILL, 32'h0, 32'h300, '0, 32'h55);
    checkOutput("cnt0_busy1", {busy_o, done_o}, 2'b10);
    @(negedge clk_i);
    checkOutput("cnt0_done", {busy_o, done_o}, 2'b01);
    @(negedge clk_i);
    checkOutput("cnt0_end", {busy_o, done_o, cyc_rises[7:0]}, 10'd0);

    $display("[TB] timeout");
    resp_en = 1'b0;
    applyStimulus(MODE_FILL, 32'h0, 32'h40, 16'd2, 32'hA5A5A5A5);
    waitDone(TIMEOUT + 20);
    repeat (5) @(negedge clk_i);
    checkOutput("to_err", err_o, 1'b1);
    checkOutput("to_cyc_len", max_run, TIMEOUT);
    checkOutput("to_one_cycle", cyc_rises, 1);
    checkOutput("to_no_write", wr_acks, 0);
    checkOutput("to_done", done_cnt, 1);
    resp_en = 1'b1;
    applyStimulus(MODE_FILL, 32'h0, 32'h40, 16'd1, 32'h0BADF00D);
    checkOutput("err_cleared", err_o, 1'b0);
    finishOp(MODE_FILL, 32'h0, 32'h40, 1, 32'h0BADF00D);

    $display("[TB] start while busy");
    applyStimulus(MODE_FILL, 32'h0, 32'h300, 16'd4, 32'h12345678);
    repeat (3) @(negedge clk_i);
    start_i = 1'b1; dst_i = 32'h380; cnt_i = 16'd2; pat_i = 32'h87654321;
    @(negedge clk_i);
    start_i = 1'b0;
    finishOp(MODE_FILL, 32'h0, 32'h300, 4, 32'h12345678);

    $display("[TB] reset mid write");
    applyStimulus(MODE_FILL, 32'h0, 32'h100, 16'd8, 32'hCAFEF00D);
    waited = 0;
    while (!(cyc_o && we_o) && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("rst_reached_wr", {cyc_o, we_o}, 2'b11);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_drop", {cyc_o, stb_o, we_o, busy_o}, 4'b0000);
    rst_i = 1'b0;
    for (int i = 0; i < MEMW; i++) model[i] = '0;
    runOp(MODE_FILL, 32'h0, 32'h20, 5, 32'h600DCAFE);

    $display("[TB] random operations");
    for (int t = 0; t < 10; t++) begin
      p = $urandom;
      runOp(1'($urandom_range(0, 1)), 32'($urandom_range(0, MEMW - 7)) * 4,
            32'($urandom_range(0, MEMW - 7)) * 4, int'($urandom_range(1, 6)), p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
